// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART loader FSM encoding, frame layout and baud timing constants
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Frame layout: 16-bit word count then 32-bit words, every field MSB byte first
    localparam int          LEN_BYTES      = 2;
    localparam int          BYTES_PER_WORD = 4;
    localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);
    localparam bit          MSB_FIRST      = 1'b1;

    localparam int CLK_FREQ_HZ   = 100_000_000;
    localparam int BAUD_RATE     = 115_200;
    localparam int CLKS_PER_BIT  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CLKS_HALF_BIT = CLKS_PER_BIT / 2;

endpackage

// File: rtl/uart_timeout.sv
// rtl/uart_timeout.sv - inter-byte idle counter that flags expiry after TIMEOUT_CYCLES-1 quiet cycles
module uart_timeout #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // A byte arriving in the expiry cycle wins over the timeout
    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - receives a length-prefixed word frame from a UART and writes it to memory
module uart_loader
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    input  logic                  start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  load_done,
    output logic                  error
);

    state_t                  state, state_next;
    logic [7:0]              count_hi;
    logic [15:0]             remaining;
    logic [23:0]             shift;
    logic [1:0]              byte_idx;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    last_word;
    logic                    start_load;
    logic                    tmo_enable;
    logic                    expired;

    assign busy       = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA);
    assign load_done  = (state == ST_DONE);
    assign tmo_enable = busy;

    uart_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (tmo_enable),
        .clear   (rx_done),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_load = 1'b1;
                    state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_done)      state_next = ST_LEN_LO;
                else if (expired) state_next = ST_IDLE;
            end
            ST_LEN_LO: begin
                if (rx_done)      state_next = ({count_hi, rx_data} == 16'd0) ? ST_DONE : ST_DATA;
                else if (expired) state_next = ST_IDLE;
            end
            ST_DATA: begin
                // Leave while the final write strobe is on the bus so LOAD_DONE trails it by one cycle
                if (last_word)    state_next = ST_DONE;
                else if (rx_done) state_next = ST_DATA;
                else if (expired) state_next = ST_IDLE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            error     <= 1'b0;
            count_hi  <= '0;
            remaining <= '0;
            shift     <= '0;
            byte_idx  <= '0;
            word_idx  <= '0;
            last_word <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start_load) begin
                error     <= 1'b0;
                count_hi  <= '0;
                remaining <= '0;
                shift     <= '0;
                byte_idx  <= '0;
                word_idx  <= '0;
                last_word <= 1'b0;
            end
            case (state)
                ST_LEN_HI: begin
                    if (rx_done)      count_hi <= rx_data;
                    else if (expired) error    <= 1'b1;
                end
                ST_LEN_LO: begin
                    if (rx_done)      remaining <= {count_hi, rx_data};
                    else if (expired) error     <= 1'b1;
                end
                ST_DATA: begin
                    if (last_word) begin
                        last_word <= 1'b0;
                    end else if (rx_done) begin
                        shift    <= {shift[15:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == LAST_BYTE_IDX) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {shift, rx_data};
                            mem_addr  <= word_idx;
                            word_idx  <= word_idx + 1'b1;
                            remaining <= remaining - 16'd1;
                            last_word <= (remaining == 16'd1);
                        end
                    end else if (expired) begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed self-checking bench for uart_loader
module tb_uart_loader;
    localparam int AW  = 2;
    localparam int TMO = 50;

    logic          clk;
    logic          reset_n;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          load_done;
    logic          error;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int ld_cnt = 0;
    int we_base, ld_base;

    uart_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .load_done (load_done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1)    we_cnt++;
        if (load_done === 1'b1) ld_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    logic [31:0] words [0:2];

    initial begin
        reset_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; start = 1'b0;
        words[0] = 32'h11223344; words[1] = 32'h55667788; words[2] = 32'h99AABBCC;
        tick(); tick();
        chk("rst_we", {31'b0, mem_we}, 0);
        chk("rst_addr", {30'b0, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, load_done}, 0);
        chk("rst_err", {31'b0, error}, 0);
        reset_n = 1'b1;
        tick();

        // single word DEADBEEF
        we_base = we_cnt; ld_base = ld_cnt;
        do_start();
        chk("t1_busy", {31'b0, busy}, 1);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        chk("t1_we_early", {31'b0, mem_we}, 0);
        send_byte(8'hEF);
        chk("t1_we", {31'b0, mem_we}, 1);
        chk("t1_addr", {30'b0, mem_addr}, 0);
        chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t1_done_early", {31'b0, load_done}, 0);
        tick();
        chk("t1_done", {31'b0, load_done}, 1);
        chk("t1_we_off", {31'b0, mem_we}, 0);
        chk("t1_wdata_hold", mem_wdata, 32'hDEADBEEF);
        tick();
        chk("t1_done_off", {31'b0, load_done}, 0);
        chk("t1_idle", {31'b0, busy}, 0);
        chk("t1_we_cnt", we_cnt - we_base, 1);
        chk("t1_ld_cnt", ld_cnt - ld_base, 1);

        // zero-length frame
        we_base = we_cnt; ld_base = ld_cnt;
        do_start();
        send_byte(8'h00); send_byte(8'h00);
        chk("t2_done", {31'b0, load_done}, 1);
        chk("t2_busy", {31'b0, busy}, 0);
        tick();
        chk("t2_done_off", {31'b0, load_done}, 0);
        chk("t2_we_cnt", we_cnt - we_base, 0);
        chk("t2_ld_cnt", ld_cnt - ld_base, 1);

        // three words
        we_base = we_cnt; ld_base = ld_cnt;
        do_start();
        send_byte(8'h00); send_byte(8'h03);
        for (int w = 0; w < 3; w++) begin
            send_word(words[w]);
            chk("t3_we", {31'b0, mem_we}, 1);
            chk("t3_addr", {30'b0, mem_addr}, w);
            chk("t3_wdata", mem_wdata, words[w]);
        end
        tick();
        chk("t3_done", {31'b0, load_done}, 1);
        tick();
        chk("t3_we_cnt", we_cnt - we_base, 3);
        chk("t3_ld_cnt", ld_cnt - ld_base, 1);

        // five words with a 2-bit address: wraps back to 0
        we_base = we_cnt; ld_base = ld_cnt;
        do_start();
        send_byte(8'h00); send_byte(8'h05);
        for (int w = 0; w < 5; w++) begin
            send_word({4{8'(w + 1)}});
            chk("t4_addr", {30'b0, mem_addr}, w % 4);
            chk("t4_wdata", mem_wdata, {4{8'(w + 1)}});
        end
        send_byte(8'h77);
        chk("t4_addr_hold", {30'b0, mem_addr}, 0);
        tick();
        chk("t4_we_cnt", we_cnt - we_base, 5);
        chk("t4_ld_cnt", ld_cnt - ld_base, 1);

        // timeout after a partial second word
        we_base = we_cnt; ld_base = ld_cnt;
        do_start();
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'hCAFEF00D);
        send_byte(8'h01);
        repeat (TMO - 1) tick();
        chk("t5_err_early", {31'b0, error}, 0);
        chk("t5_busy_early", {31'b0, busy}, 1);
        tick();
        chk("t5_err", {31'b0, error}, 1);
        chk("t5_busy", {31'b0, busy}, 0);
        chk("t5_done", {31'b0, load_done}, 0);
        tick();
        chk("t5_we_cnt", we_cnt - we_base, 1);
        chk("t5_ld_cnt", ld_cnt - ld_base, 0);
        chk("t5_err_hold", {31'b0, error}, 1);

        // restart clears error, then reset mid-DATA
        do_start();
        chk("t6_err_clr", {31'b0, error}, 0);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_we", {31'b0, mem_we}, 0);
        chk("t6_addr", {30'b0, mem_addr}, 0);
        chk("t6_wdata", mem_wdata, 0);
        chk("t6_busy", {31'b0, busy}, 0);
        chk("t6_done", {31'b0, load_done}, 0);
        chk("t6_err", {31'b0, error}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        we_base = we_cnt; ld_base = ld_cnt;
        send_word(32'h01020304);
        tick();
        chk("t6_no_we", we_cnt - we_base, 0);
        chk("t6_no_busy", {31'b0, busy}, 0);

        // START during DATA and a byte coincident with expiry
        we_base = we_cnt; ld_base = ld_cnt;
        do_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12);
        do_start();
        chk("t7_busy", {31'b0, busy}, 1);
        send_byte(8'h34);
        repeat (TMO - 1) tick();
        send_byte(8'h56);
        chk("t7_err", {31'b0, error}, 0);
        chk("t7_busy2", {31'b0, busy}, 1);
        send_byte(8'h78);
        chk("t7_we", {31'b0, mem_we}, 1);
        chk("t7_wdata", mem_wdata, 32'h12345678);
        chk("t7_addr", {30'b0, mem_addr}, 0);
        tick();
        chk("t7_done", {31'b0, load_done}, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t7_start_in_done", {31'b0, busy}, 0);
        tick();
        chk("t7_we_cnt", we_cnt - we_base, 1);
        chk("t7_ld_cnt", ld_cnt - ld_base, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
